// File: rtl/move_ctrl.sv
// ---------------------------------------------------------------------------
// move_ctrl
//
// Conditions the four raw push-buttons for the cursor position block. Each
// button is synchronised and debounced. The debounced vector is reduced to a
// single valid direction. Valid directions produce one-cycle move strobes
// with hold-to-repeat.
//
// Ports:
//   clk                      system clock, all logic on the rising edge
//   reset                    synchronous, active-high reset
//   btn_up/down/left/right   raw asynchronous buttons, active-high
//   up/down/left/right       registered one-cycle move strobes (at most one high)
//   held                     high while a direction is latched (DELAY or REPEAT)
// ---------------------------------------------------------------------------
module move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 30000000,
    parameter int REPEAT_RATE     = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic held
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    // Bit order throughout is {up, down, left, right}.
    logic [3:0] btn_raw;
    logic [3:0] db_level;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    // ------------------------------------------------------------------
    // Per-button 2-flop synchroniser and debouncer.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic            s1_reg;
            logic            s2_reg;
            logic            stable_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg     <= 1'b0;
                    s2_reg     <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    s1_reg <= btn_raw[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        // This sample is the last of the required run of
                        // consecutive differing samples.
                        stable_reg <= s2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign db_level[gi] = stable_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Direction decode: a direction is valid only if exactly one button is
    // down. Opposing or multiple presses count as no direction.
    // ------------------------------------------------------------------
    logic dir_valid;
    assign dir_valid = (db_level != 4'b0000) && ((db_level & (db_level - 4'd1)) == 4'b0000);

    // ------------------------------------------------------------------
    // Strobe / repeat FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_reg, state_next;
    logic [3:0]       dir_reg, dir_next;
    logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic [3:0]       strobe_reg, strobe_next;
    logic [RPT_W-1:0] term_cnt;

    // The repeat counter is shared by both states. Only the terminal count
    // differs.
    assign term_cnt = (state_reg == DELAY) ? RPT_W'(REPEAT_DELAY - 1)
                                           : RPT_W'(REPEAT_RATE - 1);

    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        rpt_cnt_next = rpt_cnt_reg;
        strobe_next  = 4'b0000;
        case (state_reg)
            IDLE: begin
                if (dir_valid) begin
                    strobe_next  = db_level;
                    dir_next     = db_level;
                    rpt_cnt_next = '0;
                    state_next   = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!dir_valid) begin
                    rpt_cnt_next = '0;
                    state_next   = IDLE;
                end else if (db_level != dir_reg) begin
                    // Direct switch to a new direction restarts the full
                    // initial delay.
                    strobe_next  = db_level;
                    dir_next     = db_level;
                    rpt_cnt_next = '0;
                    state_next   = DELAY;
                end else if (rpt_cnt_reg == term_cnt) begin
                    strobe_next  = dir_reg;
                    rpt_cnt_next = '0;
                    state_next   = REPEAT;
                end else begin
                    rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
                end
            end
            default: begin
                rpt_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            dir_reg     <= 4'b0000;
            rpt_cnt_reg <= '0;
            strobe_reg  <= 4'b0000;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            rpt_cnt_reg <= rpt_cnt_next;
            strobe_reg  <= strobe_next;
        end
    end

    assign {up, down, left, right} = strobe_reg;
    assign held = (state_reg != IDLE);

endmodule

// File: tb/tb_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_move_ctrl
//
// Self-checking bench for move_ctrl with small timing parameters.
// Expected strobe events (cycle, direction) are derived from the timing rules.
// A raw level sampled at edge k debounces at edge k+DB+1. It gives a strobe
// registered at edge k+DB+2, then repeats after RD and then every RR cycles.
// The strobes stop once the release has debounced.
// These expected events are queued as the stimulus is driven. A monitor pops
// and compares them as the strobes appear. The held level is checked every
// cycle against expected windows.
// ---------------------------------------------------------------------------
module tb_move_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    localparam logic [3:0] D_UP    = 4'b1000;
    localparam logic [3:0] D_DOWN  = 4'b0100;
    localparam logic [3:0] D_LEFT  = 4'b0010;
    localparam logic [3:0] D_RIGHT = 4'b0001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic up, down, left, right, held;

    move_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .held      (held)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] d;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [3:0] dir;
        int         hold;
        int         exp_n;
        string      name;
    } vec_t;
    vec_t vecs[8];

    int errors = 0;
    int checks = 0;
    int obs_count = 0;
    bit hchk = 1'b0;
    int hlo0 = 1, hhi0 = 0, hlo1 = 1, hhi1 = 0;

    logic [3:0] mon_s;
    ev_t        mon_e;
    bit         mon_eh;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon_s = {up, down, left, right};
        if (reset) begin
            check("reset_outputs", int'({mon_s, held}), 0);
        end else begin
            if (mon_s != 4'b0000) begin
                obs_count++;
                check("strobe_onehot", int'($onehot(mon_s)), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe at cycle %0d: got dir %b, want none", cyc, mon_s);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_cycle", cyc, mon_e.c);
                    check("strobe_dir", int'(mon_s), int'(mon_e.d));
                end
            end
            if (hchk) begin
                mon_eh = ((cyc >= hlo0) && (cyc <= hhi0)) || ((cyc >= hlo1) && (cyc <= hhi1));
                check("held", int'(held), int'(mon_eh));
            end
        end
    end

    // Stimulus helpers. They are always entered just after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until the next rising edge is edge e.
    task automatic goto_edge(input int e);
        while (cyc < e - 1) tick(1);
    endtask

    task automatic set_btns(input logic [3:0] d);
        {btn_up, btn_down, btn_left, btn_right} = d;
    endtask

    task automatic push_ev(input int c, input logic [3:0] d);
        exp_q.push_back('{c: c, d: d});
    endtask

    // Queue the strobes of a single clean hold: raw high for h samples from edge k.
    task automatic push_hold(input logic [3:0] d, input int k, input int h);
        int e;
        if ($onehot(d) && h >= DB) begin
            e = DB + 2;
            while (e <= h + DB + 1) begin
                push_ev(k + e, d);
                e = e + ((e == DB + 2) ? RD : RR);
            end
        end
    endtask

    task automatic clear_windows();
        hlo0 = 1; hhi0 = 0; hlo1 = 1; hhi1 = 0;
    endtask

    task automatic end_vec(input string name, input int base, input int exp_n);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_count"}, obs_count - base, exp_n);
        exp_q.delete();
        clear_windows();
        $display("vector %s: strobes=%0d expected=%0d", name, obs_count - base, exp_n);
    endtask

    initial begin
        int k, r, base;

        vecs[0] = '{dir: D_UP,                    hold: 40, exp_n: 11, name: "up_hold40"};
        vecs[1] = '{dir: D_RIGHT,                 hold: 3,  exp_n: 0,  name: "right_glitch3"};
        vecs[2] = '{dir: D_UP | D_DOWN,           hold: 30, exp_n: 0,  name: "up_down_both"};
        vecs[3] = '{dir: D_LEFT,                  hold: 4,  exp_n: 1,  name: "left_min4"};
        vecs[4] = '{dir: D_DOWN,                  hold: 21, exp_n: 5,  name: "down_hold21"};
        vecs[5] = '{dir: D_RIGHT,                 hold: 15, exp_n: 3,  name: "right_hold15"};
        vecs[6] = '{dir: D_LEFT,                  hold: 16, exp_n: 3,  name: "left_hold16"};
        vecs[7] = '{dir: D_DOWN | D_LEFT | D_RIGHT, hold: 20, exp_n: 0, name: "three_buttons"};

        // Reset with left held. After reset the press counts as new.
        reset = 1'b1;
        btn_left = 1'b1;
        tick(3);
        reset = 1'b0;
        hchk = 1'b1;
        base = obs_count;
        k = cyc + 1;
        push_hold(D_LEFT, k, 12);
        hlo0 = k + DB + 2;
        hhi0 = k + 12 + DB + 1;
        goto_edge(k + 12);
        btn_left = 1'b0;
        tick(20);
        end_vec("reset_left", base, 2);

        // Table-driven single holds and multi-button holds.
        for (int i = 0; i < 8; i++) begin
            base = obs_count;
            k = cyc + 1;
            set_btns(vecs[i].dir);
            if ($onehot(vecs[i].dir) && vecs[i].hold >= DB) begin
                hlo0 = k + DB + 2;
                hhi0 = k + vecs[i].hold + DB + 1;
            end
            push_hold(vecs[i].dir, k, vecs[i].hold);
            goto_edge(k + vecs[i].hold);
            set_btns(4'b0000);
            tick(20);
            end_vec(vecs[i].name, base, vecs[i].exp_n);
        end

        // Bounce right 1,0,1,0, with one sample each.
        base = obs_count;
        btn_right = 1'b1; tick(1);
        btn_right = 1'b0; tick(1);
        btn_right = 1'b1; tick(1);
        btn_right = 1'b0;
        tick(20);
        end_vec("right_bounce", base, 0);

        // Down held, then left added before the first repeat: the FSM drops
        // to IDLE. Releasing down leaves left alone, and left strobes
        // immediately.
        base = obs_count;
        k = cyc + 1;
        btn_down = 1'b1;
        push_ev(k + 6, D_DOWN);
        hlo0 = k + 6;
        hhi0 = k + 14;
        goto_edge(k + 9);
        btn_left = 1'b1;
        r = k + 25;
        goto_edge(r);
        btn_down = 1'b0;
        push_ev(r + 6, D_LEFT);
        hlo1 = r + 6;
        hhi1 = r + 13;
        goto_edge(r + 8);
        btn_left = 1'b0;
        tick(20);
        end_vec("down_then_left", base, 2);

        // Up into REPEAT, then a clean switch to right. Right strobes at
        // once, and its first repeat comes after the full delay.
        base = obs_count;
        k = cyc + 1;
        btn_up = 1'b1;
        push_ev(k + 6, D_UP);
        push_ev(k + 16, D_UP);
        push_ev(k + 19, D_UP);
        push_ev(k + 22, D_UP);
        push_ev(k + 25, D_UP);
        push_ev(k + 26, D_RIGHT);
        push_ev(k + 36, D_RIGHT);
        push_ev(k + 39, D_RIGHT);
        push_ev(k + 42, D_RIGHT);
        push_ev(k + 45, D_RIGHT);
        hlo0 = k + 6;
        hhi0 = k + 45;
        goto_edge(k + 20);
        btn_up = 1'b0;
        btn_right = 1'b1;
        goto_edge(k + 40);
        btn_right = 1'b0;
        tick(20);
        end_vec("up_to_right", base, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
